// File: rtl/missile_hit_resolver_pkg.sv
// Shared sizing constants and resolver state encoding for the missile hit resolver.
package missile_hit_resolver_pkg;

    localparam int NUM_MISSILES = 8;
    localparam int ALIEN_ID_W   = 6;
    localparam int POINTS       = 10;
    localparam int SCORE_W      = 16;

    typedef enum logic [1:0] {
        R_IDLE,
        R_CHECK,
        R_EMIT
    } resolver_state_t;

endpackage

// File: rtl/missile_hit_resolver_if.sv
// Raster/missile inputs and kill/retire/score outputs of the missile hit resolver.
interface missile_hit_resolver_if
    import missile_hit_resolver_pkg::*;
;
    logic [11:0]             pixel_row;
    logic [11:0]             pixel_column;
    logic [NUM_MISSILES-1:0] missle_active;
    logic [NUM_MISSILES-1:0] missle_en;
    logic                    alien_active;
    logic [ALIEN_ID_W-1:0]   alien_id;

    // Kill handshake: an event transfers on a clock edge where kill_valid && kill_ready;
    // once kill_valid rises, kill_valid and kill_id hold until that edge.
    logic                    kill_valid;
    logic [ALIEN_ID_W-1:0]   kill_id;
    logic                    kill_ready;

    logic [NUM_MISSILES-1:0] missle_retire;
    logic [SCORE_W-1:0]      score;
    logic                    overrun;

    modport master (
        output pixel_row, pixel_column, missle_active, missle_en, alien_active, alien_id,
        output kill_ready,
        input  kill_valid, kill_id, missle_retire, score, overrun
    );

    modport slave (
        input  pixel_row, pixel_column, missle_active, missle_en, alien_active, alien_id,
        input  kill_ready,
        output kill_valid, kill_id, missle_retire, score, overrun
    );

endinterface

// File: rtl/missile_hit_resolver_hit_capture.sv
// Per-pixel missile/alien overlap capture; first hit of each missile wins until the next snapshot.
module missile_hit_resolver_hit_capture
    import missile_hit_resolver_pkg::*;
(
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [NUM_MISSILES-1:0]                 missle_active,
    input  logic [NUM_MISSILES-1:0]                 missle_en,
    input  logic                                    alien_active,
    input  logic [ALIEN_ID_W-1:0]                   alien_id,
    input  logic                                    snap,
    output logic [NUM_MISSILES-1:0]                 snap_hit,
    output logic [NUM_MISSILES-1:0][ALIEN_ID_W-1:0] snap_id
);

    logic [NUM_MISSILES-1:0]                 hit;
    logic [NUM_MISSILES-1:0][ALIEN_ID_W-1:0] hit_id;
    logic [NUM_MISSILES-1:0]                 new_hit;

    assign new_hit = missle_active & missle_en & {NUM_MISSILES{alien_active}} & ~hit;

    // The snapshot cycle drops any overlap on that pixel so the new frame starts clean.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit      <= '0;
            hit_id   <= '0;
            snap_hit <= '0;
            snap_id  <= '0;
        end else if (snap) begin
            snap_hit <= hit;
            snap_id  <= hit_id;
            hit      <= '0;
        end else begin
            for (int i = 0; i < NUM_MISSILES; i++) begin
                if (new_hit[i]) begin
                    hit[i]    <= 1'b1;
                    hit_id[i] <= alien_id;
                end
            end
        end
    end

endmodule

// File: rtl/missile_hit_resolver.sv
// Frame-start detection, per-frame hit resolution into kill events / retire pulses, and saturating score.
module missile_hit_resolver
    import missile_hit_resolver_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    missile_hit_resolver_if.slave  bus,
    output resolver_state_t        dbg_state
);

    localparam int                IDX_W     = $clog2(NUM_MISSILES);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_MISSILES - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    resolver_state_t                         state, state_n;
    logic [IDX_W-1:0]                        idx, idx_n;
    logic                                    origin_q, frame_start_q;
    logic [(1 << ALIEN_ID_W)-1:0]            killed;
    logic [SCORE_W-1:0]                      score_q;
    logic                                    overrun_q;
    logic [NUM_MISSILES-1:0]                 snap_hit;
    logic [NUM_MISSILES-1:0][ALIEN_ID_W-1:0] snap_id;
    logic                                    snap, mark_kill, kill_valid;
    logic [NUM_MISSILES-1:0]                 retire;
    logic                                    at_origin, cur_hit, last;
    logic [ALIEN_ID_W-1:0]                   cur_id;
    logic [SCORE_W:0]                        score_sum;

    missile_hit_resolver_hit_capture u_capture (
        .clk           (clk),
        .rst           (rst),
        .missle_active (bus.missle_active),
        .missle_en     (bus.missle_en),
        .alien_active  (bus.alien_active),
        .alien_id      (bus.alien_id),
        .snap          (snap),
        .snap_hit      (snap_hit),
        .snap_id       (snap_id)
    );

    assign at_origin = (bus.pixel_row == 12'd0) && (bus.pixel_column == 12'd0);
    assign cur_hit   = snap_hit[idx];
    assign cur_id    = snap_id[idx];
    assign last      = (idx == LAST_IDX);
    assign score_sum = {1'b0, score_q} + (SCORE_W + 1)'(POINTS);

    always_comb begin
        state_n    = state;
        idx_n      = idx;
        snap       = 1'b0;
        kill_valid = 1'b0;
        mark_kill  = 1'b0;
        retire     = '0;
        case (state)
            R_IDLE: begin
                if (frame_start_q) begin
                    snap    = 1'b1;
                    idx_n   = '0;
                    state_n = R_CHECK;
                end
            end
            R_CHECK: begin
                if (cur_hit && !killed[cur_id]) begin
                    state_n = R_EMIT;
                end else begin
                    retire[idx] = cur_hit;
                    state_n     = last ? R_IDLE : R_CHECK;
                    idx_n       = last ? idx : idx + 1'b1;
                end
            end
            R_EMIT: begin
                kill_valid = 1'b1;
                if (bus.kill_ready) begin
                    retire[idx] = 1'b1;
                    mark_kill   = 1'b1;
                    state_n     = last ? R_IDLE : R_CHECK;
                    idx_n       = last ? idx : idx + 1'b1;
                end
            end
            default: state_n = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= R_IDLE;
            idx           <= '0;
            origin_q      <= 1'b0;
            frame_start_q <= 1'b0;
            killed        <= '0;
            score_q       <= '0;
            overrun_q     <= 1'b0;
        end else begin
            state         <= state_n;
            idx           <= idx_n;
            origin_q      <= at_origin;
            frame_start_q <= at_origin && !origin_q;
            if (snap)
                killed <= '0;
            else if (mark_kill)
                killed[cur_id] <= 1'b1;
            if (mark_kill)
                score_q <= score_sum[SCORE_W] ? SCORE_MAX : score_sum[SCORE_W-1:0];
            // A frame boundary while still resolving is lost for good; flag it.
            if (frame_start_q && state != R_IDLE)
                overrun_q <= 1'b1;
        end
    end

    assign bus.kill_valid    = kill_valid;
    assign bus.kill_id       = kill_valid ? cur_id : '0;
    assign bus.missle_retire = retire;
    assign bus.score         = score_q;
    assign bus.overrun       = overrun_q;
    assign dbg_state         = state;

endmodule

// File: tb/tb_missile_hit_resolver.sv
// Randomized and directed frames against a frame-level reference model with a decoupled scoreboard.
module tb_missile_hit_resolver;
    import missile_hit_resolver_pkg::*;

    localparam int EW = 1 + ALIEN_ID_W + NUM_MISSILES;

    logic            clk = 1'b0;
    logic            rst;
    resolver_state_t dbg_state;

    missile_hit_resolver_if bus();

    missile_hit_resolver dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int ready_mode = 0;   // 0 random, 1 always ready, 2 never ready

    // ---------------- reference model ----------------
    logic [NUM_MISSILES-1:0] m_hit = '0;
    logic [ALIEN_ID_W-1:0]   m_id [NUM_MISSILES];
    int unsigned             m_score = 0;
    bit                      merge_next = 1'b0;
    logic [NUM_MISSILES-1:0] frame_en;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        n_cmp++;
        if (got !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, got, req);
        end
    endtask

    // Turn one frame's first hits into the ordered event list: missiles in index order,
    // first missile on an alien kills it, later ones on the same alien only retire.
    task automatic resolve_model();
        bit dead [1 << ALIEN_ID_W];
        logic [NUM_MISSILES-1:0] oh;
        for (int i = 0; i < NUM_MISSILES; i++) begin
            if (m_hit[i]) begin
                oh    = '0;
                oh[i] = 1'b1;
                if (dead[m_id[i]]) begin
                    exp_q.push_back({1'b0, ALIEN_ID_W'(0), oh});
                end else begin
                    dead[m_id[i]] = 1'b1;
                    exp_q.push_back({1'b1, m_id[i], oh});
                    m_score = (m_score + POINTS > 65535) ? 65535 : m_score + POINTS;
                end
            end
        end
        m_hit = '0;
    endtask

    task automatic drive_pixel(input int r, input int c, input logic [NUM_MISSILES-1:0] act,
                               input logic [NUM_MISSILES-1:0] en, input logic aa,
                               input logic [ALIEN_ID_W-1:0] aid);
        @(posedge clk);
        #1;
        if (r == 0 && c == 0) begin
            if (!merge_next) resolve_model();
            merge_next = 1'b0;
        end
        bus.pixel_row     = 12'(r);
        bus.pixel_column  = 12'(c);
        bus.missle_active = act;
        bus.missle_en     = en;
        bus.alien_active  = aa;
        bus.alien_id      = aid;
        for (int i = 0; i < NUM_MISSILES; i++)
            if (act[i] && en[i] && aa && !m_hit[i]) begin
                m_hit[i] = 1'b1;
                m_id[i]  = aid;
            end
    endtask

    task automatic run_frame(input int mode, input int nr, input int nc);
        logic [NUM_MISSILES-1:0] act, en;
        logic                    aa;
        logic [ALIEN_ID_W-1:0]   aid;
        frame_en = NUM_MISSILES'($urandom | $urandom);
        for (int r = 0; r < nr; r++) begin
            for (int c = 0; c < nc; c++) begin
                act = '0; en = '1; aa = 1'b0; aid = '0;
                case (mode)
                    0: if (r != 0) begin
                        aa  = ($urandom_range(3) == 0);
                        aid = ALIEN_ID_W'($urandom_range(7));
                        act = NUM_MISSILES'($urandom & $urandom & $urandom);
                        en  = frame_en;
                    end
                    1: if (r == 2 && c == 5) begin act = 8'b0000_0100; aa = 1'b1; aid = 6'd17; end
                    2: if (r == 2 && c == 5) begin act = 8'b0010_0001; aa = 1'b1; aid = 6'd3; end
                    3: begin
                        if (r == 1 && c == 3) begin act = 8'b0000_0010; aa = 1'b1; aid = 6'd4; end
                        if (r == 3 && c == 7) begin act = 8'b0000_0010; aa = 1'b1; aid = 6'd9; end
                    end
                    4: if (r == 2 && c == 5) begin act = '1; en = '0; aa = 1'b1; aid = 6'd12; end
                    6: if (r == 1 && c == 4) begin act = 8'b0000_1000; aa = 1'b1; aid = 6'd20; end
                    7: if (r == 2 && c == 2) begin act = 8'b0001_1000; aa = 1'b1; aid = 6'd21; end
                    8: if (r == 1 && c < NUM_MISSILES) begin
                        act = NUM_MISSILES'(1) << c; aa = 1'b1; aid = ALIEN_ID_W'(c * 5 + 1);
                    end
                    default: ;
                endcase
                drive_pixel(r, c, act, en, aa, aid);
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) drive_pixel(1, 0, '0, '0, 1'b0, '0);
    endtask

    task automatic wait_drain(input string name);
        int t = 0;
        while (exp_q.size() != 0 && t < 400) begin
            @(posedge clk);
            t++;
        end
        check({"drain_", name}, exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // ---------------- kill_ready driver ----------------
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       bus.kill_ready = ($urandom_range(3) != 0);
            1:       bus.kill_ready = 1'b1;
            default: bus.kill_ready = 1'b0;
        endcase
    end

    // ---------------- monitor ----------------
    logic [EW-1:0] mon_got, mon_exp;
    bit            mon_have;
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            mon_have = 1'b0;
            if (bus.kill_valid && bus.kill_ready) begin
                mon_got  = {1'b1, bus.kill_id, bus.missle_retire};
                mon_have = 1'b1;
            end else if (bus.missle_retire != '0) begin
                mon_got  = {1'b0, ALIEN_ID_W'(0), bus.missle_retire};
                mon_have = 1'b1;
            end
            if (mon_have) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_event: got %h, expected none", mon_got);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (mon_got !== mon_exp) begin
                        n_err++;
                        $display("FAIL event: got %h, expected %h", mon_got, mon_exp);
                    end
                end
            end
            if (bus.kill_valid && !bus.kill_ready && exp_q.size() != 0)
                check("stalled_kill_id", bus.kill_id, exp_q[0][NUM_MISSILES +: ALIEN_ID_W]);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b1;
        bus.pixel_row = 12'd1; bus.pixel_column = 12'd0;
        bus.missle_active = '0; bus.missle_en = '0;
        bus.alien_active = 1'b0; bus.alien_id = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_kill_valid", bus.kill_valid, 0);
        check("rst_kill_id", bus.kill_id, 0);
        check("rst_retire", bus.missle_retire, 0);
        check("rst_score", bus.score, 0);
        check("rst_overrun", bus.overrun, 0);
        check("rst_state", dbg_state, R_IDLE);
        rst = 1'b0;

        ready_mode = 0;
        for (int f = 0; f < 30; f++) run_frame(0, 8, 16);
        run_frame(9, 8, 16);
        wait_drain("random");
        check("random_score", bus.score, m_score);
        check("random_overrun", bus.overrun, 0);

        for (int t = 1; t <= 4; t++) begin
            run_frame(t, 8, 16);
            run_frame(9, 8, 16);
            wait_drain("directed");
            check("directed_score", bus.score, m_score);
        end

        // Kill held off across a frame boundary: new-frame hits merge into the next snapshot.
        ready_mode = 2;
        run_frame(1, 8, 16);
        run_frame(6, 8, 16);
        merge_next = 1'b1;
        run_frame(7, 8, 16);
        check("overrun_set", bus.overrun, 1);
        ready_mode = 1;
        idle_cycles(20);
        run_frame(9, 8, 16);
        run_frame(9, 8, 16);
        wait_drain("overrun");
        check("overrun_score", bus.score, m_score);
        check("overrun_sticky", bus.overrun, 1);

        ready_mode = 1;
        for (int f = 0; f < 830; f++) run_frame(8, 2, 12);
        run_frame(9, 2, 12);
        wait_drain("saturate");
        check("score_saturated", bus.score, 32'd65535);

        // Reset while a kill is being offered.
        ready_mode = 2;
        run_frame(1, 8, 16);
        drive_pixel(0, 0, '0, '0, 1'b0, '0);
        for (int k = 1; k < 40 && !bus.kill_valid; k++) drive_pixel(0, k, '0, '0, 1'b0, '0);
        check("emit_reached", bus.kill_valid, 1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_kill_valid", bus.kill_valid, 0);
        check("midrst_kill_id", bus.kill_id, 0);
        check("midrst_retire", bus.missle_retire, 0);
        check("midrst_score", bus.score, 0);
        check("midrst_overrun", bus.overrun, 0);
        exp_q.delete();
        m_hit   = '0;
        m_score = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("post_rst_kill_valid", bus.kill_valid, 0);
        check("post_rst_state", dbg_state, R_IDLE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
